// File: rtl/colossal_demo_if.sv
// colossal_demo_if: TinyTapeout user-tile pin bundle for colossal_demo.
//   ena     : tile enable
//   ui_in   : [7]=we, [6]=bank_sel, [5:0]=addr
//   uio_in  : write data
//   uo_out  : registered read data
//   uio_out : bidirectional output value (constant zero)
//   uio_oe  : bidirectional output enable (constant zero, all inputs)
interface colossal_demo_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/colossal_demo.sv
// colossal_demo: two-bank, 64 x 8-bit flop register file on a TinyTapeout tile.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears all entries and uo_out)
//   bus : slave side of colossal_demo_if (ena, ui_in, uio_in in; uo_out,
//         uio_out, uio_oe out)
// Writes are written through to uo_out; reads appear on uo_out one cycle
// after the address is sampled. ena=0 freezes all state.
module colossal_demo (
    input  logic                 clk,
    input  logic                 rst,
    colossal_demo_if.slave       bus
);
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_BANKS = 2;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    logic              we;
    logic              bank_sel;
    logic [ADDR_W-1:0] addr;

    logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0] mem_d [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0] uo_q;
    logic [DATA_W-1:0] uo_d;

    // Field decode of the dedicated inputs
    assign we       = bus.ui_in[7];
    assign bank_sel = bus.ui_in[6];
    assign addr     = bus.ui_in[ADDR_W-1:0];

    // Next-state: write updates one entry and passes the byte through;
    // read captures the addressed entry
    always_comb begin
        mem_d = mem_q;
        uo_d  = uo_q;
        if (bus.ena) begin
            if (we) begin
                mem_d[bank_sel][addr] = bus.uio_in;
                uo_d                  = bus.uio_in;
            end else begin
                uo_d = mem_q[bank_sel][addr];
            end
        end
    end

    // State registers; reset wins over ena and any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int a = 0; a < int'(DEPTH); a++) begin
                    mem_q[b][a] <= DATA_W'(0);
                end
            end
            uo_q <= DATA_W'(0);
        end else begin
            mem_q <= mem_d;
            uo_q  <= uo_d;
        end
    end

    assign bus.uo_out  = uo_q;
    assign bus.uio_out = DATA_W'(0);
    assign bus.uio_oe  = DATA_W'(0);
endmodule

// File: tb/tb_colossal_demo.sv
// tb_colossal_demo: directed plus randomized check of colossal_demo against
// an array-based behavioural model of the two-bank register file.
module tb_colossal_demo;
    logic clk = 1'b0;
    logic rst;

    colossal_demo_if bus ();

    colossal_demo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference state: plain 2-D byte array and expected output byte
    logic [7:0] ref_mem [2][64];
    logic [7:0] ref_out;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1ns after the edge
    task automatic step(input logic r, input logic e, input logic w, input logic b,
                        input logic [5:0] a, input logic [7:0] d);
        rst        = r;
        bus.ena    = e;
        bus.ui_in  = {w, b, a};
        bus.uio_in = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 64; j++)
                    ref_mem[i][j] = 8'h00;
            ref_out = 8'h00;
        end else if (e) begin
            if (w) begin
                ref_mem[b][a] = d;
                ref_out       = d;
            end else begin
                ref_out = ref_mem[b][a];
            end
        end
        #1;
        check_eq("uo_out_model", bus.uo_out, ref_out);
        check_eq("uio_out", bus.uio_out, 8'h00);
        check_eq("uio_oe", bus.uio_oe, 8'h00);
    endtask

    task automatic wr(input logic b, input logic [5:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, 1'b1, b, a, d);
    endtask

    task automatic rd(input logic b, input logic [5:0] a);
        step(1'b0, 1'b1, 1'b0, b, a, 8'h00);
    endtask

    logic [7:0] sweep_val;

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        ref_out    = 8'hxx;

        // 1. Reset then read corners of both banks
        step(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 8'h5A);
        check_eq("reset_out", bus.uo_out, 8'h00);
        rd(1'b0, 6'd0);
        check_eq("reset_b0a0", bus.uo_out, 8'h00);
        rd(1'b1, 6'd63);
        check_eq("reset_b1a63", bus.uo_out, 8'h00);

        // 2. Basic write/read with write-through
        wr(1'b0, 6'd5, 8'hA5);
        check_eq("wr_through", bus.uo_out, 8'hA5);
        rd(1'b1, 6'd5);
        check_eq("other_bank_a5", bus.uo_out, 8'h00);
        rd(1'b0, 6'd5);
        check_eq("basic_rd", bus.uo_out, 8'hA5);

        // 3. Bank isolation
        wr(1'b0, 6'd10, 8'h11);
        wr(1'b1, 6'd10, 8'h22);
        rd(1'b0, 6'd10);
        check_eq("iso_b0", bus.uo_out, 8'h11);
        rd(1'b1, 6'd10);
        check_eq("iso_b1", bus.uo_out, 8'h22);

        // 4. Full sweep of both banks
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 64; a++) begin
                sweep_val = (8'(a) ^ {1'(b), 7'h00}) + 8'd3;
                wr(1'(b), 6'(a), sweep_val);
            end
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 64; a++) begin
                sweep_val = (8'(a) ^ {1'(b), 7'h00}) + 8'd3;
                rd(1'(b), 6'(a));
                check_eq("sweep", bus.uo_out, sweep_val);
            end
        rd(1'b0, 6'd0);
        check_eq("sweep_b0a0", bus.uo_out, 8'h03);
        rd(1'b0, 6'd63);
        check_eq("sweep_b0a63", bus.uo_out, 8'h42);
        rd(1'b1, 6'd0);
        check_eq("sweep_b1a0", bus.uo_out, 8'h83);
        rd(1'b1, 6'd63);
        check_eq("sweep_b1a63", bus.uo_out, 8'hC2);

        // 5. ena gating: blocked write, frozen output
        wr(1'b1, 6'd7, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 1'b1, 6'd7, 8'hFF);
        check_eq("ena0_hold", bus.uo_out, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        check_eq("ena0_hold_rd", bus.uo_out, 8'h3C);
        rd(1'b0, 6'd0);
        rd(1'b1, 6'd7);
        check_eq("ena_gated_wr", bus.uo_out, 8'h3C);

        // 6. Reset mid-operation discards concurrent write
        wr(1'b0, 6'd1, 8'h77);
        step(1'b1, 1'b1, 1'b1, 1'b0, 6'd2, 8'h99);
        check_eq("midrst_out", bus.uo_out, 8'h00);
        rd(1'b0, 6'd1);
        check_eq("midrst_a1", bus.uo_out, 8'h00);
        rd(1'b0, 6'd2);
        check_eq("midrst_a2", bus.uo_out, 8'h00);

        // Randomized traffic against the model, occasional reset and ena drop
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
        end

        // Final readback of every entry against the model
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 64; a++)
                rd(1'(b), 6'(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/colossal_demo.md
Name: colossal_demo

Overview:
- Two-bank, 64-entry x 8-bit register-file memory (128 bytes total) in the standard TinyTapeout user-tile pinout.
- Address, bank select and write enable come in on the dedicated inputs. Write data comes in on the bidirectional pins, which are used as inputs only.
- Read data is driven out on the dedicated outputs.
- Top-level user block of the tile; no submodules are required beyond the storage array.

Parameters:
- ADDR_W, 6, address width per bank; depth is 2**ADDR_W = 64.
- DATA_W, 8, word width.
- NUM_BANKS, 2, number of banks, selected by one bit.
- All three are fixed by the pinout; any other values are unsupported.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  tile enable; when 0, no writes occur and all registered state holds.
- ui_in  input  8  [7]=we, [6]=bank_sel, [5:0]=addr.
- uio_in  input  8  write data.
- uo_out  output  8  registered read data.
- uio_out  output  8  tied to 8'h00.
- uio_oe  output  8  tied to 8'h00; all bidirectional pins are inputs.

Behaviour:
- Storage: mem[bank][addr], with bank = ui_in[6] and addr = ui_in[5:0]. Implemented as flops; no SRAM macro.
- Reset (rst=1 at a rising clk edge):
  - all 128 entries are cleared to 8'h00;
  - uo_out register is cleared to 8'h00.
  - Reset has priority over ena and we.
  - Reset asserted mid-sequence discards any write presented in that cycle.
- Write (rst=0, ena=1, we=1 at an edge): mem[bank_sel][addr] <= uio_in. The other bank at the same addr is unaffected.
- Read (rst=0, ena=1, we=0 at an edge): uo_out <= mem[bank_sel][addr].
  - One-cycle latency: the value is visible after the edge that samples the address.
- Write cycle output: uo_out <= uio_in (write-through), i.e. the newly written byte appears on uo_out one cycle later.
- ena=0: the memory and uo_out hold their values; we is ignored.
- Back-to-back write then read of the same location returns the new data; there is no read-after-write hazard.
- Address wrap: none needed; all 6-bit values are valid. addr=63 and addr=0 are independent entries.
- Banks are fully independent: the same addr in bank 0 and bank 1 are distinct bytes.
- uio_out and uio_oe are constant 8'h00 at all times, including during reset.
- There is no combinational path from inputs to uo_out.

Test Plan:
1. Reset: rst=1 for 2 cycles, then read bank0 addr0, bank1 addr63 -> uo_out=8'h00 for both; uio_oe=8'h00 and uio_out=8'h00 throughout.
2. Basic write/read: write 8'hA5 to bank0 addr5, then read bank0 addr5 -> uo_out=8'hA5 one cycle after the read address is applied. The write cycle itself also yields uo_out=8'hA5.
3. Bank isolation: write 8'h11 to bank0 addr10 and 8'h22 to bank1 addr10 -> reads return 8'h11 and 8'h22 respectively.
4. Full sweep: write (addr ^ {bank,7'h00}) + 3 to every location in both banks, then read all 128 -> every value matches; addr0 and addr63 of each bank are explicitly checked.
5. ena gating: write 8'h3C to bank1 addr7, set ena=0, attempt a write of 8'hFF to the same location, restore ena=1 and read -> 8'h3C. uo_out holds its prior value while ena=0.
6. Reset mid-operation: write 8'h77 to bank0 addr1, assert rst for one cycle together with a write of 8'h99 to bank0 addr2, then read both -> 8'h00 and 8'h00.
